// File: rtl/seq_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_detector
// Description : Run-time loadable serial pattern detector. It supports
//               overlapping or non-overlapping matching and keeps a
//               saturating match counter.
//               Optional feature macro: SEQ_DET_MASK_EN (adds a per-bit
//               don't-care mask).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_detector #(
    parameter int PAT_WIDTH = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 In1,
    input  logic                 In_valid,
    input  logic [PAT_WIDTH-1:0] Pattern,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_WIDTH-1:0] Pattern_mask,
`endif
    input  logic                 Pattern_load,
    input  logic                 Overlap,
    input  logic                 Cnt_clr,
    output logic                 Out1,
    output logic [CNT_WIDTH-1:0] Match_count,
    output logic                 Cnt_sat,
    output logic                 Armed
);

    localparam int                    c_FILL_W    = $clog2(PAT_WIDTH + 1);
    localparam logic [c_FILL_W-1:0]   c_FILL_FULL = c_FILL_W'(PAT_WIDTH);
    localparam logic [c_FILL_W-1:0]   c_FILL_ONE  = c_FILL_W'(1);
    localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_UNARMED = 2'd0,
        S_FILL    = 2'd1,
        S_SEARCH  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PAT_WIDTH-1:0]   r_hist;
    logic [PAT_WIDTH-1:0]   r_pat;
    logic [c_FILL_W-1:0]    r_fill;
    logic                   r_out1;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   r_sat;
    logic                   r_armed;

    logic                   w_consume;
    logic [PAT_WIDTH-1:0]   w_hist_nxt;
    logic [c_FILL_W-1:0]    w_fill_nxt;
    logic                   w_full;
    logic [PAT_WIDTH-1:0]   w_diff;
    logic                   w_match;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_WIDTH-1:0]   r_mask;
    assign w_diff = (w_hist_nxt ^ r_pat) & ~r_mask;
`else
    assign w_diff = w_hist_nxt ^ r_pat;
`endif

    // A load in the same cycle swallows the incoming bit.
    assign w_consume  = (r_state != S_UNARMED) && In_valid && !Pattern_load;
    assign w_hist_nxt = {r_hist[PAT_WIDTH-2:0], In1};
    assign w_fill_nxt = (r_fill == c_FILL_FULL) ? r_fill : r_fill + c_FILL_ONE;
    assign w_full     = (w_fill_nxt == c_FILL_FULL);
    assign w_match    = w_consume && w_full && (w_diff == '0);
    assign w_cnt_nxt  = (r_count == c_CNT_MAX) ? r_count : r_count + c_CNT_ONE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_UNARMED;
            r_hist  <= '0;
            r_pat   <= '0;
            r_fill  <= '0;
            r_out1  <= 1'b0;
            r_count <= '0;
            r_sat   <= 1'b0;
            r_armed <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            r_mask  <= '0;
`endif
        end else begin
            r_out1 <= w_match;

            if (Pattern_load) begin
                r_pat   <= Pattern;
`ifdef SEQ_DET_MASK_EN
                r_mask  <= Pattern_mask;
`endif
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= S_FILL;
                r_armed <= 1'b1;
            end else if (w_consume) begin
                r_hist <= w_hist_nxt;
                // Non-overlapping: restart the fill so no bit is reused.
                if (w_match && !Overlap) begin
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end else begin
                    r_fill  <= w_fill_nxt;
                    r_state <= w_full ? S_SEARCH : S_FILL;
                end
            end

            if (Cnt_clr) begin
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (w_match) begin
                r_count <= w_cnt_nxt;
                if (w_cnt_nxt == c_CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign Out1        = r_out1;
    assign Match_count = r_count;
    assign Cnt_sat     = r_sat;
    assign Armed       = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
`default_nettype none
// Testbench for seq_pattern_detector: directed vectors with hand-computed results.
// A second instance with CNT_WIDTH=2 shares all inputs to exercise saturation.
module tb_seq_pattern_detector;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       In1 = 1'b0;
    logic       In_valid = 1'b0;
    logic [3:0] Pattern = 4'b0000;
`ifdef SEQ_DET_MASK_EN
    logic [3:0] Pattern_mask = 4'b0000;
`endif
    logic       Pattern_load = 1'b0;
    logic       Overlap = 1'b1;
    logic       Cnt_clr = 1'b0;

    logic       out1_a, sat_a, armed_a;
    logic [7:0] cnt_a;
    logic       out1_b, sat_b, armed_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    seq_pattern_detector #(.PAT_WIDTH(4), .CNT_WIDTH(8)) u_dut (
        .CLK(CLK), .RST(RST), .In1(In1), .In_valid(In_valid), .Pattern(Pattern),
`ifdef SEQ_DET_MASK_EN
        .Pattern_mask(Pattern_mask),
`endif
        .Pattern_load(Pattern_load), .Overlap(Overlap), .Cnt_clr(Cnt_clr),
        .Out1(out1_a), .Match_count(cnt_a), .Cnt_sat(sat_a), .Armed(armed_a)
    );

    seq_pattern_detector #(.PAT_WIDTH(4), .CNT_WIDTH(2)) u_dut_c2 (
        .CLK(CLK), .RST(RST), .In1(In1), .In_valid(In_valid), .Pattern(Pattern),
`ifdef SEQ_DET_MASK_EN
        .Pattern_mask(Pattern_mask),
`endif
        .Pattern_load(Pattern_load), .Overlap(Overlap), .Cnt_clr(Cnt_clr),
        .Out1(out1_b), .Match_count(cnt_b), .Cnt_sat(sat_b), .Armed(armed_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bit_in(input logic b, input logic v);
        In1 = b;
        In_valid = v;
        tick();
        In_valid = 1'b0;
    endtask

    task automatic load(input logic [3:0] pat);
        Pattern = pat;
        Pattern_load = 1'b1;
        tick();
        Pattern_load = 1'b0;
    endtask

    task automatic clear_cnt();
        Cnt_clr = 1'b1;
        tick();
        Cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (out1_a !== 1'b0) begin errors++; $display("FAIL reset_out1: got %b want 0", out1_a); end
        checks++;
        if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
        checks++;
        if (sat_a !== 1'b0 || sat_b !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b/%b want 0/0", sat_a, sat_b); end
        checks++;
        if (armed_a !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b want 0", armed_a); end
        RST = 1'b0;
        // Unarmed: bits are ignored even if they would spell a pattern.
        bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1);
        checks++;
        if (out1_a !== 1'b0 || armed_a !== 1'b0) begin
            errors++; $display("FAIL unarmed_ignore: out1=%b armed=%b want 0/0", out1_a, armed_a);
        end
    endtask

    task automatic test_basic();
        logic [3:0] s;
        clear_cnt();
        load(4'b1011);
        checks++;
        if (armed_a !== 1'b1) begin errors++; $display("FAIL basic_armed: got %b want 1", armed_a); end
        s = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            bit_in(s[3-i], 1'b1);
            checks++;
            if (out1_a !== (i == 3)) begin errors++; $display("FAIL basic_out1[%0d]: got %b want %b", i, out1_a, (i == 3)); end
        end
        checks++;
        if (cnt_a !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", cnt_a); end
        tick();
        checks++;
        if (out1_a !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b want 0", out1_a); end
    endtask

    task automatic run_stream(input logic ov, input logic [7:0] exp, input logic [7:0] exp_cnt, input string nm);
        logic [7:0] s;
        s = 8'b10101010;
        Overlap = ov;
        clear_cnt();
        load(4'b1010);
        for (int i = 0; i < 8; i++) begin
            bit_in(s[7-i], 1'b1);
            checks++;
            if (out1_a !== exp[i]) begin errors++; $display("FAIL %s_out1[%0d]: got %b want %b", nm, i, out1_a, exp[i]); end
        end
        checks++;
        if (cnt_a !== exp_cnt) begin errors++; $display("FAIL %s_count: got %0d want %0d", nm, cnt_a, exp_cnt); end
        Overlap = 1'b1;
    endtask

    task automatic test_overlap();
        run_stream(1'b1, 8'b1010_1000, 8'd3, "overlap");
        run_stream(1'b0, 8'b1000_1000, 8'd2, "nonoverlap");
    endtask

    task automatic test_valid_gap();
        clear_cnt();
        load(4'b1011);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bit_in(1'b1, 1'b0);
            checks++;
            if (out1_a !== 1'b0) begin errors++; $display("FAIL gap_out1[%0d]: got %b want 0", i, out1_a); end
        end
        bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b0) begin errors++; $display("FAIL gap_early: got %b want 0", out1_a); end
        bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b1) begin errors++; $display("FAIL gap_pulse: got %b want 1", out1_a); end
        checks++;
        if (cnt_a !== 8'd1) begin errors++; $display("FAIL gap_count: got %0d want 1", cnt_a); end
    endtask

    task automatic test_saturate();
        int m;
        Overlap = 1'b1;
        clear_cnt();
        load(4'b1111);
        for (int i = 0; i < 8; i++) begin
            bit_in(1'b1, 1'b1);
            m = (i >= 3) ? i - 2 : 0;
            checks++;
            if (cnt_b !== 2'((m > 3) ? 3 : m) || sat_b !== (m >= 3)) begin
                errors++; $display("FAIL sat_small[%0d]: cnt=%0d sat=%b want %0d/%b", i, cnt_b, sat_b, (m > 3) ? 3 : m, (m >= 3));
            end
            checks++;
            if (cnt_a !== 8'(m) || sat_a !== 1'b0) begin
                errors++; $display("FAIL sat_big[%0d]: cnt=%0d sat=%b want %0d/0", i, cnt_a, sat_a, m);
            end
        end
        Cnt_clr = 1'b1;
        bit_in(1'b1, 1'b1);
        Cnt_clr = 1'b0;
        checks++;
        if (out1_a !== 1'b1) begin errors++; $display("FAIL clr_match_pulse: got %b want 1", out1_a); end
        checks++;
        if (cnt_a !== 8'd0 || cnt_b !== 2'd0 || sat_b !== 1'b0) begin
            errors++; $display("FAIL clr_wins: cnt=%0d/%0d sat=%b want 0/0/0", cnt_a, cnt_b, sat_b);
        end
    endtask

    task automatic test_rst_mid();
        clear_cnt();
        load(4'b1011);
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        RST = 1'b1;
        tick();
        checks++;
        if (armed_a !== 1'b0 || armed_b !== 1'b0) begin errors++; $display("FAIL rst_armed: got %b/%b want 0/0", armed_a, armed_b); end
        RST = 1'b0;
        load(4'b1011);
        checks++;
        if (armed_a !== 1'b1) begin errors++; $display("FAIL rst_rearm: got %b want 1", armed_a); end
        bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: got %b want 0", out1_a); end
        bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b0) begin errors++; $display("FAIL rst_early: got %b want 0", out1_a); end
        bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b1 || cnt_a !== 8'd1) begin errors++; $display("FAIL rst_pulse: out1=%b cnt=%0d want 1/1", out1_a, cnt_a); end
    endtask

    task automatic test_load_priority();
        clear_cnt();
        load(4'b1011);
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        // Load with a completing bit present: the bit must be discarded.
        Pattern = 4'b1011;
        Pattern_load = 1'b1;
        bit_in(1'b1, 1'b1);
        Pattern_load = 1'b0;
        checks++;
        if (out1_a !== 1'b0 || cnt_a !== 8'd0) begin errors++; $display("FAIL load_prio: out1=%b cnt=%0d want 0/0", out1_a, cnt_a); end
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b0) begin errors++; $display("FAIL load_hist_clear: got %b want 0", out1_a); end
        bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b1 || cnt_a !== 8'd1) begin errors++; $display("FAIL load_then_match: out1=%b cnt=%0d want 1/1", out1_a, cnt_a); end
    endtask

`ifdef SEQ_DET_MASK_EN
    task automatic test_mask();
        clear_cnt();
        Pattern_mask = 4'b0110;
        load(4'b1001);
        Pattern_mask = 4'b0000;
        for (int i = 0; i < 4; i++) bit_in(1'b1, 1'b1);
        checks++;
        if (out1_a !== 1'b1 || cnt_a !== 8'd1) begin errors++; $display("FAIL mask_match: out1=%b cnt=%0d want 1/1", out1_a, cnt_a); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_valid_gap();
        test_saturate();
        test_rst_mid();
        test_load_priority();
`ifdef SEQ_DET_MASK_EN
        test_mask();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
